// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared constants and types for the wide_add_sequencer block.
//   SLICE_W : width of one adder slice (16 bits)
//   state_t : sequencer FSM states (IDLE, ADD, DONE)
// -----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : wide_add_pkg

// File: rtl/adder16.sv
// -----------------------------------------------------------------------------
// adder16
// Combinational 16-bit carry-lookahead adder: four 4-bit lookahead groups
// joined by a second lookahead level on the group generate/propagate terms.
// Ports:
//   a, b : 16-bit operands
//   cin  : carry in
//   s    : 16-bit sum
//   cout : carry out
// -----------------------------------------------------------------------------
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [15:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_grp
            localparam int B0 = 4 * gk;

            // Group generate / propagate
            assign w_gg[gk] = w_g[B0+3]
                            | (w_p[B0+3] & w_g[B0+2])
                            | (w_p[B0+3] & w_p[B0+2] & w_g[B0+1])
                            | (w_p[B0+3] & w_p[B0+2] & w_p[B0+1] & w_g[B0]);
            assign w_gp[gk] = &w_p[B0 +: 4];

            // Bit carries inside the group, expanded from the group carry-in
            assign w_c[B0]   = w_gc[gk];
            assign w_c[B0+1] = w_g[B0] | (w_p[B0] & w_gc[gk]);
            assign w_c[B0+2] = w_g[B0+1]
                             | (w_p[B0+1] & w_g[B0])
                             | (w_p[B0+1] & w_p[B0] & w_gc[gk]);
            assign w_c[B0+3] = w_g[B0+2]
                             | (w_p[B0+2] & w_g[B0+1])
                             | (w_p[B0+2] & w_p[B0+1] & w_g[B0])
                             | (w_p[B0+2] & w_p[B0+1] & w_p[B0] & w_gc[gk]);
        end
    endgenerate

    // Second-level lookahead across the four groups
    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    assign w_gc[2] = w_gg[1]
                   | (w_gp[1] & w_gg[0])
                   | (w_gp[1] & w_gp[0] & cin);
    assign w_gc[3] = w_gg[2]
                   | (w_gp[2] & w_gg[1])
                   | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    assign w_gc[4] = w_gg[3]
                   | (w_gp[3] & w_gg[2])
                   | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

    assign s    = w_p ^ w_c;
    assign cout = w_gc[4];

endmodule : adder16

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Adds two W = 16*SLICES bit operands one 16-bit slice per clock through a
// single shared adder16, least-significant slice first.
// Optional feature macro: WIDE_ADD_SUB_EN (adds the Sub input; A-B mode).
// Ports:
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   Start   : request; accepted only while idle
//   A, B    : operands, captured on the accepting edge
//   Sub     : (WIDE_ADD_SUB_EN only) subtract select, captured on accept
//   Ready   : high while idle
//   Sum     : registered result, modulo 2^W
//   CO      : registered carry out of the top slice (no-borrow in Sub mode)
//   Done    : one-cycle completion pulse
// -----------------------------------------------------------------------------
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter  int SLICES = 4,
    localparam int W      = SLICE_W * SLICES
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef WIDE_ADD_SUB_EN
    input  logic         Sub,
`endif
    output logic         Ready,
    output logic [W-1:0] Sum,
    output logic         CO,
    output logic         Done
);

    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_co;
    logic               r_done;
    logic               r_ready;
`ifdef WIDE_ADD_SUB_EN
    logic               r_sub;
`endif

    logic [SLICE_W-1:0] w_a_sl [SLICES];
    logic [SLICE_W-1:0] w_b_sl [SLICES];
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_b_op;
    logic [SLICE_W-1:0] w_s;
    logic               w_cout;
    logic               w_cin_init;
    logic [W-1:0]       w_sum_next;

    // Slice views of the latched operands; the current slice is picked by idx,
    // and only the slice idx of the result is replaced on an ADD edge.
    genvar gs;
    generate
        for (gs = 0; gs < SLICES; gs++) begin : g_slice
            assign w_a_sl[gs] = r_a[gs*SLICE_W +: SLICE_W];
            assign w_b_sl[gs] = r_b[gs*SLICE_W +: SLICE_W];
            assign w_sum_next[gs*SLICE_W +: SLICE_W] =
                (r_idx == IDX_W'(gs)) ? w_s : r_sum[gs*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_a_slice = w_a_sl[r_idx];
    assign w_b_slice = w_b_sl[r_idx];

`ifdef WIDE_ADD_SUB_EN
    // Two's-complement subtract: invert B and seed the carry with 1
    assign w_b_op     = r_sub ? ~w_b_slice : w_b_slice;
    assign w_cin_init = Sub;
`else
    assign w_b_op     = w_b_slice;
    assign w_cin_init = 1'b0;
`endif

    adder16 u_adder16 (
        .a    (w_a_slice),
        .b    (w_b_op),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef WIDE_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
`ifdef WIDE_ADD_SUB_EN
                        r_sub   <= Sub;
`endif
                        r_idx   <= '0;
                        r_carry <= w_cin_init;
                        r_ready <= 1'b0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_co    <= w_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Ready = r_ready;
    assign Sum   = r_sum;
    assign CO    = r_co;
    assign Done  = r_done;

endmodule : wide_add_sequencer

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 4, number of 16-bit slices; operand width W = 16*SLICES.
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port Start, input, 1, request to add; level-sensitive, sampled each edge.
REQ-005 SHALL have port A, input, W, first operand; captured only on the accepting edge.
REQ-006 SHALL have port B, input, W, second operand; captured only on the accepting edge.
REQ-007 SHALL have port Ready, output, 1, high only in IDLE.
REQ-008 SHALL have port Sum, output, W, registered result.
REQ-009 SHALL have port CO, output, 1, registered carry out of the top slice.
REQ-010 SHALL have port Done, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-012 SHALL accept a request on an edge where Start=1 and state=IDLE; on that edge it latches A and B, clears the slice index and carry register, and enters ADD.
REQ-013 SHALL, in ADD, feed slice idx of the latched operands plus the carry register into one shared 16-bit adder, then on the edge write the result into Sum[16*idx+:16], the adder carry-out into the carry register, and increment idx.
REQ-014 SHALL, on the ADD edge where idx=SLICES-1, load CO with the final carry and enter DONE.
REQ-015 SHALL hold Done=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-016 SHALL set latency at exactly SLICES edges from the accepting edge to DONE entry; Done rises after the SLICES-th edge.
REQ-017 SHALL ignore Start in ADD and DONE, with no effect on operands or the count.
REQ-018 SHALL, with Start held high continuously, accept one request every SLICES+2 cycles.
REQ-019 SHALL treat Sum and CO as valid from Done until the next accepting edge; they hold their value while IDLE.
REQ-020 SHALL discard any carry out of the top slice beyond CO; Sum is modulo 2^W.

Reset
REQ-021 SHALL, on Reset_n=0 at any time including mid-ADD, immediately force state=IDLE, idx=0, carry=0, Sum=0, CO=0 and Done=0, with Ready=1; the partial result is discarded.
REQ-022 SHALL accept no request while Reset_n=0.

Configuration
REQ-023 SHALL, with WIDE_ADD_SUB_EN defined, add input Sub (1 bit) latched on accept; when Sub=1, B is bit-inverted per slice, the carry register initialises to 1, and the block computes A-B with CO=1 meaning no borrow.
REQ-024 SHALL, without WIDE_ADD_SUB_EN, omit the Sub port entirely; the block is add-only and the initial carry is 0.

Structure
REQ-025 SHALL place in package wide_add_pkg: the constant SLICE_W=16 and the FSM state enum (IDLE, ADD, DONE).
REQ-026 SHALL instantiate exactly one combinational sub-module, adder16 (16-bit carry-lookahead, inputs a, b, cin; outputs s, cout), shared across all slices.
REQ-027 SHALL size idx as $clog2(SLICES) bits, minimum 1.

Verification
REQ-028 SHALL cover: reset, then A=0x0000_0000_0000_FFFF, B=1 -> Sum=0x0000_0000_0001_0000, CO=0, Done after the 4th edge post-accept.
REQ-029 SHALL cover: A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> Sum=0, CO=1; inter-slice carry propagates through all 4 slices.
REQ-030 SHALL cover: Start pulsed again during ADD with different operands -> ignored; exactly one Done with the first result; Ready=0 throughout.
REQ-031 SHALL cover: Reset_n dropped after 2 ADD edges -> same-cycle IDLE, Sum=0, CO=0, Done=0, Ready=1; a new request then completes correctly.
REQ-032 SHALL cover: Start held high with 3 operand pairs -> accepts spaced 6 cycles apart, 3 Done pulses, each result correct.
REQ-033 SHALL cover, with WIDE_ADD_SUB_EN: Sub=1, A=5, B=7 -> Sum=0xFFFF_FFFF_FFFF_FFFE, CO=0; A=7, B=5 -> Sum=2, CO=1.
